// File: rtl/ir_decode_stage.sv
// Instruction register, family classifier and condition evaluator for the ARMv4 core.
// Define IR_FLAG_BYPASS_EN to evaluate cond against alu_nzcv in a cycle where ld_cc is high.
module ir_decode_stage #(
  parameter logic [3:0]  RESET_FLAGS = 4'b0000,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_ir,
  input  logic        mem_r,
  input  logic [31:0] mem_data,
  input  logic        ld_cc,
  input  logic [3:0]  alu_nzcv,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [3:0]  family_number,
  output logic        cond,
  output logic        st,
  output logic        pl,
  output logic        a,
  output logic        ir_20,
  output logic [3:0]  flags
);

  localparam logic [3:0] FamDpImm    = 4'd0;
  localparam logic [3:0] FamDpRegSh  = 4'd1;
  localparam logic [3:0] FamMul      = 4'd2;
  localparam logic [3:0] FamSwp      = 4'd3;
  localparam logic [3:0] FamHalfword = 4'd4;
  localparam logic [3:0] FamDpImmOp  = 4'd5;
  localparam logic [3:0] FamLdrImm   = 4'd6;
  localparam logic [3:0] FamLdrReg   = 4'd7;
  localparam logic [3:0] FamLdmStm   = 4'd8;
  localparam logic [3:0] FamBranch   = 4'd9;
  localparam logic [3:0] FamLdcStc   = 4'd10;
  localparam logic [3:0] FamCoproc   = 4'd11;
  localparam logic [3:0] FamSwi      = 4'd12;
  localparam logic [3:0] FamUndef    = 4'd13;
  localparam logic [3:0] FamBx       = 4'd14;
  localparam logic [3:0] FamHalt     = 4'd15;

  logic [31:0] ir_q,     ir_d;
  logic        valid_q,  valid_d;
  logic [3:0]  family_q, family_d;
  logic [3:0]  flags_q,  flags_d;
  logic [3:0]  eval_flags;
  logic        ir_load;

  // First match wins; the ordering of the tests is significant.
  function automatic logic [3:0] classify(input logic [31:0] w);
    logic [3:0] fam;
    if (w == HALT_WORD) begin
      fam = FamHalt;
    end else if (w[27:4] == 24'h12FFF1) begin
      fam = FamBx;
    end else if (w[27:24] == 4'hF) begin
      fam = FamSwi;
    end else if (w[27:24] == 4'hE) begin
      fam = FamCoproc;
    end else begin
      unique case (w[27:25])
        3'b110:  fam = FamLdcStc;
        3'b101:  fam = FamBranch;
        3'b100:  fam = FamLdmStm;
        3'b011:  fam = w[4] ? FamUndef : FamLdrReg;
        3'b010:  fam = FamLdrImm;
        3'b001:  fam = FamDpImmOp;
        3'b000: begin
          if (w[7:4] == 4'b1001) begin
            fam = w[24] ? FamSwp : FamMul;
          end else if (w[7] && w[4]) begin
            fam = FamHalfword;
          end else if (w[4]) begin
            fam = FamDpRegSh;
          end else begin
            fam = FamDpImm;
          end
        end
        default: fam = FamCoproc;  // 3'b111 is fully covered by the 4'hE/4'hF tests above
      endcase
    end
    return fam;
  endfunction

  // f is {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v, res;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    unique case (code)
      4'h0: res = z;
      4'h1: res = !z;
      4'h2: res = c;
      4'h3: res = !c;
      4'h4: res = n;
      4'h5: res = !n;
      4'h6: res = v;
      4'h7: res = !v;
      4'h8: res = c && !z;
      4'h9: res = !c || z;
      4'hA: res = (n == v);
      4'hB: res = (n != v);
      4'hC: res = !z && (n == v);
      4'hD: res = z || (n != v);
      4'hE: res = 1'b1;
      4'hF: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign ir_load = ld_ir && mem_r;

  always_comb begin
    ir_d     = ir_q;
    valid_d  = valid_q;
    family_d = family_q;
    flags_d  = flags_q;
    if (ir_load) begin
      ir_d     = mem_data;
      valid_d  = 1'b1;
      family_d = classify(mem_data);
    end
    if (ld_cc) begin
      flags_d = alu_nzcv;
    end
  end

  // Synchronous reset takes priority over any load on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q     <= '0;
      valid_q  <= 1'b0;
      family_q <= FamDpImm;
      flags_q  <= RESET_FLAGS;
    end else begin
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      family_q <= family_d;
      flags_q  <= flags_d;
    end
  end

`ifdef IR_FLAG_BYPASS_EN
  assign eval_flags = ld_cc ? alu_nzcv : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  always_comb begin
    cond = 1'b0;
    if (valid_q) begin
      cond = cond_pass(ir_q[31:28], eval_flags);
    end
  end

  // Store direction is only meaningful for the load/store families.
  always_comb begin
    st = 1'b0;
    unique case (family_q)
      FamHalfword, FamLdrImm, FamLdrReg, FamLdmStm, FamLdcStc: st = !ir_q[20];
      default: st = 1'b0;
    endcase
  end

  assign ir            = ir_q;
  assign ir_valid      = valid_q;
  assign family_number = family_q;
  assign flags         = flags_q;
  assign pl            = ir_q[24];
  assign a             = ir_q[21];
  assign ir_20         = ir_q[20];

endmodule
